// File: rtl/spi_ss_sequencer.sv
// rtl/spi_ss_sequencer.sv - slave-select sequencer with CS setup/hold/gap timing
//
// Purpose: accepts a slave index or broadcast request, drives registered
// one-hot (or all-lines) chip selects, and frames each shift-engine transfer
// with setup, hold and inter-frame gap intervals.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present            req_ready  request accepted (IDLE only)
//   req_sel    target slave index         req_bcast  assert every line
//   abort      end current frame early    sel_err    pulse: out-of-range index
//   xfer_go    start pulse to shift engine
//   xfer_done  frame-complete pulse from shift engine
//   ss_out     registered chip selects    busy       sequencer not idle
module spi_ss_sequencer #(
   parameter int NUM_SLAVES    = 16,
   parameter int SEL_W         = 4,
   parameter int SETUP_CYC     = 2,
   parameter int HOLD_CYC      = 2,
   parameter int GAP_CYC       = 1,
   parameter bit SS_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [SEL_W-1:0]      req_sel,
   input  logic                  req_bcast,
   input  logic                  abort,
   output logic                  xfer_go,
   input  logic                  xfer_done,
   output logic [NUM_SLAVES-1:0] ss_out,
   output logic                  busy,
   output logic                  sel_err
);

   localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int MAX_CYC = (MAX_SH > GAP_CYC) ? MAX_SH : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // Pad level for a deasserted line; XOR with the asserted mask gives pad levels.
   localparam logic [NUM_SLAVES-1:0] SS_IDLE = {NUM_SLAVES{SS_ACTIVE_LOW}};

   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACTIVE,
      S_HOLD,
      S_GAP
   } state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [NUM_SLAVES-1:0]   mask, mask_nxt;
   logic [NUM_SLAVES-1:0]   req_mask;
   logic [NUM_SLAVES-1:0]   ss_act_nxt;
   logic [NUM_SLAVES-1:0]   ss_q;
   logic                    go_q, go_nxt;
   logic                    err_q, err_nxt;
   logic [31:0]             sel_ext;
   logic                    sel_in_range;

   assign sel_ext      = 32'(req_sel);
   assign sel_in_range = (sel_ext < 32'(NUM_SLAVES));

   always_comb begin
      req_mask = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         req_mask[i] = req_bcast | (sel_ext == 32'(i));
      end
   end

   // State register; chip selects, go and error pulses are registered here too
   // so the pads only ever change on a clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         mask  <= '0;
         ss_q  <= SS_IDLE;
         go_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         mask  <= mask_nxt;
         ss_q  <= ss_act_nxt ^ SS_IDLE;
         go_q  <= go_nxt;
         err_q <= err_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mask_nxt  = mask;
      go_nxt    = 1'b0;
      err_nxt   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (!req_bcast && !sel_in_range) begin
                  // Request is consumed but rejected; selects stay untouched.
                  err_nxt = 1'b1;
               end else begin
                  mask_nxt  = req_mask;
                  state_nxt = S_SETUP;
                  cnt_nxt   = SETUP_LOAD;
               end
            end
         end
         S_SETUP: begin
            if (abort) begin
               state_nxt = S_GAP;
               cnt_nxt   = GAP_LOAD;
            end else if (cnt == '0) begin
               state_nxt = S_ACTIVE;
               go_nxt    = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_ACTIVE: begin
            // abort with xfer_done lands in the same place, so no priority needed.
            if (xfer_done || abort) begin
               state_nxt = S_HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end
         S_HOLD: begin
            if (cnt == '0) begin
               state_nxt = S_GAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt == '0) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Selects are asserted exactly while the next state frames a transfer.
      if (state_nxt == S_SETUP || state_nxt == S_ACTIVE || state_nxt == S_HOLD) begin
         ss_act_nxt = mask_nxt;
      end else begin
         ss_act_nxt = '0;
      end
   end

   // Outputs
   always_comb begin
      busy      = (state != S_IDLE);
      req_ready = (state == S_IDLE) && !rst;
      ss_out    = ss_q;
      xfer_go   = go_q;
      sel_err   = err_q;
   end

endmodule

// File: tb/tb_spi_ss_sequencer.sv
// tb/tb_spi_ss_sequencer.sv - randomized timeline-model bench for spi_ss_sequencer
module tb_spi_ss_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0: default build. Index 1: 12 slaves, active-high, 3/1/2 timing.
   logic        rst_i       [2];
   logic        req_valid_i [2];
   logic [3:0]  req_sel_i   [2];
   logic        req_bcast_i [2];
   logic        abort_i     [2];
   logic        done_i      [2];
   logic        ready_o     [2];
   logic        go_o        [2];
   logic        busy_o      [2];
   logic        err_o       [2];
   logic [15:0] ss_o        [2];
   logic [15:0] ss0;
   logic [11:0] ss1;

   assign ss_o[0] = ss0;
   assign ss_o[1] = {4'h0, ss1};

   spi_ss_sequencer dut0 (
      .clk(clk), .rst(rst_i[0]), .req_valid(req_valid_i[0]), .req_ready(ready_o[0]),
      .req_sel(req_sel_i[0]), .req_bcast(req_bcast_i[0]), .abort(abort_i[0]),
      .xfer_go(go_o[0]), .xfer_done(done_i[0]), .ss_out(ss0), .busy(busy_o[0]),
      .sel_err(err_o[0])
   );

   spi_ss_sequencer #(
      .NUM_SLAVES(12), .SEL_W(4), .SETUP_CYC(3), .HOLD_CYC(1), .GAP_CYC(2),
      .SS_ACTIVE_LOW(1'b0)
   ) dut1 (
      .clk(clk), .rst(rst_i[1]), .req_valid(req_valid_i[1]), .req_ready(ready_o[1]),
      .req_sel(req_sel_i[1]), .req_bcast(req_bcast_i[1]), .abort(abort_i[1]),
      .xfer_go(go_o[1]), .xfer_done(done_i[1]), .ss_out(ss1), .busy(busy_o[1]),
      .sel_err(err_o[1])
   );

   int pn [2] = '{16, 12};
   int ps [2] = '{2, 3};
   int ph [2] = '{2, 1};
   int pg [2] = '{1, 2};
   bit pal[2] = '{1'b1, 1'b0};

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One record per clock cycle: inputs driven in that cycle and the outputs
   // that must be visible in that same cycle.
   typedef struct {
      bit         rst, valid, bcast, abort, done;
      logic [3:0] sel;
      logic [15:0] m;      // asserted lines (logical, polarity-free)
      bit         go, busy, ready, err;
   } rec_t;

   rec_t q[$];

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] rs();
      return 4'($urandom_range(0, 15));
   endfunction

   function automatic logic [15:0] all_lines(int d);
      logic [16:0] one = 17'h1;
      return 16'((one << pn[d]) - 17'h1);
   endfunction

   function automatic logic [15:0] lvl(int d, logic [15:0] m);
      return (pal[d] ? ~m : m) & all_lines(d);
   endfunction

   function automatic void push(bit r, bit v, logic [3:0] s, bit b, bit a, bit dn,
                                logic [15:0] m, bit go, bit busy, bit rdy, bit err);
      rec_t x;
      x.rst = r; x.valid = v; x.sel = s; x.bcast = b; x.abort = a; x.done = dn;
      x.m = m; x.go = go; x.busy = busy; x.ready = rdy; x.err = err;
      q.push_back(x);
   endfunction

   // kind: 0 xfer_done, 1 abort in SETUP at offset apos, 2 abort alone in ACTIVE,
   //       3 abort together with xfer_done, 4 reset held 3 cycles from the go cycle
   function automatic void gen_frame(int d, int kind, logic [3:0] sel, bit bc, int dly, int apos);
      logic [15:0] m;
      bit inv;
      inv = !bc && (int'(sel) >= pn[d]);
      m   = bc ? all_lines(d) : (16'h1 << sel);
      push(0, 1, sel, bc, rb(), rb(), 16'h0, 0, 0, 1, 0);
      if (inv) begin
         push(0, 0, rs(), rb(), rb(), rb(), 16'h0, 0, 0, 1, 1);
         return;
      end
      for (int i = 0; i < ps[d]; i++) begin
         if (kind == 1 && i == apos) begin
            push(0, rb(), rs(), rb(), 1, rb(), m, 0, 1, 0, 0);
            for (int g = 0; g < pg[d]; g++) push(0, rb(), rs(), rb(), rb(), rb(), 16'h0, 0, 1, 0, 0);
            return;
         end
         push(0, rb(), rs(), rb(), 0, rb(), m, 0, 1, 0, 0);
      end
      if (kind == 4) begin
         push(1, 0, 4'h0, 0, 0, 0, m, 1, 1, 0, 0);
         push(1, 0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
         push(1, 0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
         return;
      end
      for (int j = 0; j <= dly; j++) begin
         bit last;
         last = (j == dly);
         push(0, rb(), rs(), rb(), last && kind >= 2, last && kind != 2, m, j == 0, 1, 0, 0);
      end
      for (int h = 0; h < ph[d]; h++) push(0, rb(), rs(), rb(), rb(), rb(), m, 0, 1, 0, 0);
      for (int g = 0; g < pg[d]; g++) push(0, rb(), rs(), rb(), rb(), rb(), 16'h0, 0, 1, 0, 0);
   endfunction

   function automatic void idle_rec(int n);
      for (int i = 0; i < n; i++) push(0, 0, rs(), rb(), rb(), rb(), 16'h0, 0, 0, 1, 0);
   endfunction

   function automatic void rand_frame(int d);
      int k;
      k = $urandom_range(0, 9);
      k = (k >= 4) ? ((k == 9) ? 4 : 0) : k;
      gen_frame(d, k, rs(), ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                $urandom_range(0, ps[d] - 1));
      if ($urandom_range(0, 2) == 0) idle_rec($urandom_range(1, 2));
   endfunction

   task automatic run(input int d);
      rec_t r;
      for (int i = 0; i < q.size(); i++) begin
         r = q[i];
         @(negedge clk);
         rst_i[d]       = r.rst;
         req_valid_i[d] = r.valid;
         req_sel_i[d]   = r.sel;
         req_bcast_i[d] = r.bcast;
         abort_i[d]     = r.abort;
         done_i[d]      = r.done;
         #1;
         chk($sformatf("d%0d c%0d ss_out", d, i), 32'(ss_o[d]), 32'(lvl(d, r.m)));
         chk($sformatf("d%0d c%0d xfer_go", d, i), 32'(go_o[d]), 32'(r.go));
         chk($sformatf("d%0d c%0d busy", d, i), 32'(busy_o[d]), 32'(r.busy));
         chk($sformatf("d%0d c%0d req_ready", d, i), 32'(ready_o[d]), 32'(r.ready));
         chk($sformatf("d%0d c%0d sel_err", d, i), 32'(err_o[d]), 32'(r.err));
      end
      @(negedge clk);
      rst_i[d] = 0; req_valid_i[d] = 0; req_bcast_i[d] = 0; abort_i[d] = 0; done_i[d] = 0;
      q.delete();
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_i[d] = 1; req_valid_i[d] = 0; req_sel_i[d] = 0;
         req_bcast_i[d] = 0; abort_i[d] = 0; done_i[d] = 0;
      end
      repeat (3) @(negedge clk);

      // Default build
      push(1, 0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
      idle_rec(1);
      gen_frame(0, 4, 4'd7, 0, 0, 0);
      gen_frame(0, 0, 4'd5, 0, 3, 0);
      for (int k = 0; k < 16; k++) gen_frame(0, 0, 4'(k), 0, 0, 0);
      gen_frame(0, 0, 4'd3, 1, 1, 0);
      gen_frame(0, 1, 4'd9, 0, 0, 0);
      gen_frame(0, 1, 4'd2, 0, 0, 1);
      gen_frame(0, 3, 4'd4, 0, 0, 0);
      gen_frame(0, 3, 4'd4, 0, 2, 0);
      gen_frame(0, 2, 4'd6, 0, 1, 0);
      for (int n = 0; n < 40; n++) rand_frame(0);
      idle_rec(2);
      run(0);

      // 12-slave active-high build
      push(1, 0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
      idle_rec(1);
      gen_frame(1, 0, 4'd13, 0, 0, 0);
      gen_frame(1, 0, 4'd12, 0, 0, 0);
      gen_frame(1, 0, 4'd11, 0, 1, 0);
      gen_frame(1, 0, 4'd3, 1, 0, 0);
      gen_frame(1, 0, 4'd15, 1, 2, 0);
      gen_frame(1, 1, 4'd0, 0, 0, 2);
      gen_frame(1, 4, 4'd1, 0, 0, 0);
      for (int n = 0; n < 30; n++) rand_frame(1);
      idle_rec(2);
      run(1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
